// File: rtl/seg_pkg.sv
// Shared types, constants and helpers for the multiplexed 7-segment scan controller.
package seg_pkg;

  typedef enum logic [1:0] {IDLE, BLANK, DRIVE} scan_state_t;

  localparam int MAX_DIGITS = 8;
  localparam logic [MAX_DIGITS-1:0] ANODE_OFF = '1;

  function automatic logic [3:0] nibble_sel(input logic [4*MAX_DIGITS-1:0] vec,
                                            input logic [2:0]              idx);
    return vec[4*idx +: 4];
  endfunction

endpackage

// File: rtl/seg_slot_timer.sv
// Down-counting slot timer: load starts a slot, tc is high while the count sits at zero.
module seg_slot_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic             tc
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign tc = (count == '0);

endmodule

// File: rtl/seg_scan_ctrl.sv
// Digit scanner for a multiplexed hex display with anti-ghost blanking and frame-aligned value latching.
// Define SEG_LZ_BLANK_EN to suppress leading zeros (digit 0 is always shown).
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int CLK_DIV      = 50000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    load,
  output logic [3:0]              digit_hex,
  output logic [NUM_DIGITS-1:0]   an_n,
  output logic                    dp_n,
  output logic                    frame_done
);

  localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CNT_MAX = (CLK_DIV > BLANK_CYCLES) ? CLK_DIV : BLANK_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_DIGITS - 1);
  localparam logic [CNT_W-1:0] BLANK_LOAD = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] DRIVE_LOAD = CNT_W'(CLK_DIV - 1);

  scan_state_t state, state_nxt;
  logic [IDX_W-1:0]        idx, idx_nxt;
  logic                    tmr_load, tmr_clear, tc;
  logic [CNT_W-1:0]        tmr_val;
  logic                    boundary;
  logic [4*NUM_DIGITS-1:0] shadow_val, shadow_val_nxt, pend_val;
  logic [NUM_DIGITS-1:0]   shadow_dp, shadow_dp_nxt, pend_dp;
  logic                    pend_valid;
  logic [4*MAX_DIGITS-1:0] shadow_ext;
  logic                    lz_blank;

  seg_slot_timer #(.WIDTH(CNT_W)) u_slot_timer (
    .clk      (clk),
    .reset    (reset),
    .clear    (tmr_clear),
    .load     (tmr_load),
    .load_val (tmr_val),
    .tc       (tc)
  );

  always_comb begin
    state_nxt  = state;
    idx_nxt    = idx;
    tmr_load   = 1'b0;
    tmr_clear  = 1'b0;
    tmr_val    = BLANK_LOAD;
    boundary   = 1'b0;
    frame_done = 1'b0;
    if (!enable) begin
      state_nxt = IDLE;
      idx_nxt   = '0;
      tmr_clear = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          state_nxt = BLANK;
          idx_nxt   = '0;
          tmr_load  = 1'b1;
          boundary  = 1'b1;
        end
        BLANK: begin
          if (tc) begin
            state_nxt = DRIVE;
            tmr_load  = 1'b1;
            tmr_val   = DRIVE_LOAD;
          end
        end
        DRIVE: begin
          if (tc) begin
            state_nxt = BLANK;
            tmr_load  = 1'b1;
            if (idx == LAST_IDX) begin
              idx_nxt    = '0;
              boundary   = 1'b1;
              frame_done = !reset;
            end else begin
              idx_nxt = idx + 1'b1;
            end
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // A load landing on the boundary bypasses pending so it shows in the very next frame.
  always_comb begin
    shadow_val_nxt = shadow_val;
    shadow_dp_nxt  = shadow_dp;
    if (boundary) begin
      if (load) begin
        shadow_val_nxt = value;
        shadow_dp_nxt  = dp_in;
      end else if (pend_valid) begin
        shadow_val_nxt = pend_val;
        shadow_dp_nxt  = pend_dp;
      end
    end
  end

  always_comb begin
    shadow_ext                   = '0;
    shadow_ext[4*NUM_DIGITS-1:0] = shadow_val_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      idx        <= '0;
      shadow_val <= '0;
      shadow_dp  <= '0;
      pend_val   <= '0;
      pend_dp    <= '0;
      pend_valid <= 1'b0;
      digit_hex  <= 4'h0;
    end else begin
      state      <= state_nxt;
      idx        <= idx_nxt;
      shadow_val <= shadow_val_nxt;
      shadow_dp  <= shadow_dp_nxt;
      if (boundary) begin
        pend_valid <= 1'b0;
      end else if (load) begin
        pend_val   <= value;
        pend_dp    <= dp_in;
        pend_valid <= 1'b1;
      end
      // Decoder input changes only on blank entry so segments settle while anodes are off.
      if (state_nxt == BLANK && state != BLANK) begin
        digit_hex <= nibble_sel(shadow_ext, 3'(idx_nxt));
      end else if (state_nxt == IDLE) begin
        digit_hex <= 4'h0;
      end
    end
  end

`ifdef SEG_LZ_BLANK_EN
  logic [IDX_W-1:0] msd;
  always_comb begin
    msd = '0;
    for (int i = 1; i < NUM_DIGITS; i++) begin
      if (shadow_val[4*i +: 4] != 4'h0) msd = IDX_W'(i);
    end
  end
  assign lz_blank = (idx > msd);
`else
  assign lz_blank = 1'b0;
`endif

  always_comb begin
    an_n = ANODE_OFF[NUM_DIGITS-1:0];
    dp_n = 1'b1;
    if (state == DRIVE) begin
      if (!lz_blank) an_n[idx] = 1'b0;
      dp_n = ~shadow_dp[idx];
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: frame-position model checked every cycle plus pinned literal points.
module tb_seg_scan_ctrl;

  localparam int ND    = 4;
  localparam int CDIV  = 4;
  localparam int BLNK  = 2;
  localparam int SLOT  = BLNK + CDIV;
  localparam int FRAME = ND * SLOT;

  logic          clk;
  logic          reset, enable, load;
  logic [15:0]   value;
  logic [3:0]    dp_in;
  logic [3:0]    digit_hex, an_n;
  logic          dp_n, frame_done;

  int n_checks = 0;
  int n_fail   = 0;
  int p;
  bit check_en = 0;

  seg_scan_ctrl #(.NUM_DIGITS(ND), .CLK_DIV(CDIV), .BLANK_CYCLES(BLNK)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .value      (value),
    .dp_in      (dp_in),
    .load       (load),
    .digit_hex  (digit_hex),
    .an_n       (an_n),
    .dp_n       (dp_n),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: scan position counted from the start of scanning; shown value changes only at frame starts.
  bit          m_active = 0, m_fresh = 0, m_pv = 0;
  int          m_t = 0;
  logic [15:0] m_show = '0, m_pend = '0;
  logic [3:0]  m_sdp = '0, m_pdp = '0;

  task automatic xfer();
    if (load) begin
      m_show = value; m_sdp = dp_in; m_pv = 0;
    end else if (m_pv) begin
      m_show = m_pend; m_sdp = m_pdp; m_pv = 0;
    end
  endtask

  always @(posedge clk) begin
    if (reset) begin
      m_active = 0; m_t = 0; m_show = '0; m_sdp = '0;
      m_pend = '0; m_pdp = '0; m_pv = 0; m_fresh = 1;
    end else if (!enable) begin
      if (load) begin m_pend = value; m_pdp = dp_in; m_pv = 1; end
      m_active = 0;
    end else if (!m_active) begin
      xfer();
      m_active = 1; m_t = 0; m_fresh = 0;
    end else begin
      if (m_t % FRAME == FRAME - 1) xfer();
      else if (load) begin m_pend = value; m_pdp = dp_in; m_pv = 1; end
      m_t++;
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      logic [3:0] e_an, e_hex;
      logic       e_dp, e_fd, lit;
      int pos, d, ph, msd;
      e_an = 4'hF; e_hex = 4'h0; e_dp = 1'b1; e_fd = 1'b0;
      if (m_active) begin
        pos = m_t % FRAME; d = pos / SLOT; ph = pos % SLOT;
        msd = 0;
        for (int i = 1; i < ND; i++) if (m_show[4*i +: 4] != 4'h0) msd = i;
        lit = 1'b1;
`ifdef SEG_LZ_BLANK_EN
        lit = (d == 0) || (d <= msd);
`endif
        e_hex = m_show[4*d +: 4];
        if (ph >= BLNK) begin
          if (lit) e_an = ~(4'b0001 << d);
          e_dp = ~m_sdp[d];
        end
        e_fd = (pos == FRAME - 1) && enable && !reset;
      end
      chk("model_an_n", an_n, e_an);
      chk("model_dp_n", dp_n, e_dp);
      chk("model_frame_done", frame_done, e_fd);
      if (m_active || m_fresh) chk("model_digit_hex", digit_hex, e_hex);
      chk("anode_onehot", ($countones(~an_n) <= 1), 1);
    end
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
    p += n;
  endtask

  task automatic go(input int target);
    step(target - p);
  endtask

  task automatic start_scan();
    p = -1;
  endtask

  initial begin
    reset = 1; enable = 0; load = 0; value = '0; dp_in = '0; p = 0;
    @(posedge clk); #1;
    check_en = 1;
    step(1);
    chk("rst_an_n", an_n, 4'hF);
    chk("rst_dp_n", dp_n, 1'b1);
    chk("rst_hex", digit_hex, 4'h0);
    chk("rst_fd", frame_done, 1'b0);

    reset = 0; enable = 1; value = 16'h1234; dp_in = 4'b0000; load = 1; start_scan();
    step(1); load = 0;
    chk("f0_blank_an", an_n, 4'hF);
    chk("f0_blank_hex", digit_hex, 4'h4);
    go(2);  chk("f0_d0_an", an_n, 4'b1110); chk("f0_d0_hex", digit_hex, 4'h4);
    go(8);  chk("f0_d1_an", an_n, 4'b1101); chk("f0_d1_hex", digit_hex, 4'h3);
    go(22); chk("f0_fd_early", frame_done, 1'b0);
    go(23); chk("f0_fd", frame_done, 1'b1);
    go(24); chk("f1_fd_clear", frame_done, 1'b0); chk("f1_start_an", an_n, 4'hF);

    go(34); value = 16'hABCD; load = 1; step(1); load = 0;
    go(44); chk("f1_d3_hex_old", digit_hex, 4'h1); chk("f1_d3_an", an_n, 4'b0111);
    go(50); chk("f2_d0_hex_new", digit_hex, 4'hD); chk("f2_d0_an", an_n, 4'b1110);

    go(55); value = 16'h5678; load = 1; step(1); load = 0;
    go(57); value = 16'h9ABC; dp_in = 4'b0100; load = 1; step(1); load = 0;
    go(84); chk("f3_d2_blank_dp", dp_n, 1'b1); chk("f3_d2_blank_an", an_n, 4'hF);
    go(86); chk("f3_d2_hex", digit_hex, 4'hA); chk("f3_d2_dp", dp_n, 1'b0);
    chk("f3_d2_an", an_n, 4'b1011);

    go(95); value = 16'h0F00; dp_in = 4'b0000; load = 1; step(1); load = 0;
    go(104); chk("f4_d1_hex_bnd", digit_hex, 4'h0); chk("f4_d1_an", an_n, 4'b1101);
    step(1); enable = 0;
    step(1); chk("dis_an", an_n, 4'hF); chk("dis_dp", dp_n, 1'b1);
    value = 16'h4321; load = 1; step(1); load = 0;
    step(2);

    enable = 1; start_scan();
    step(1); chk("re_blank_an", an_n, 4'hF); chk("re_blank_hex", digit_hex, 4'h1);
    go(2); chk("re_d0_an", an_n, 4'b1110);

    go(3); reset = 1;
    step(1);
    chk("mid_rst_an", an_n, 4'hF); chk("mid_rst_dp", dp_n, 1'b1);
    chk("mid_rst_hex", digit_hex, 4'h0); chk("mid_rst_fd", frame_done, 1'b0);
    reset = 0; start_scan();
    step(1); go(2); chk("post_rst_d0_an", an_n, 4'b1110); chk("post_rst_hex", digit_hex, 4'h0);
    go(30);

`ifdef SEG_LZ_BLANK_EN
    reset = 1; step(2);
    reset = 0; value = 16'h0007; load = 1; start_scan();
    step(1); load = 0;
    go(2);  chk("lz_d0_an", an_n, 4'b1110); chk("lz_d0_hex", digit_hex, 4'h7);
    go(8);  chk("lz_d1_dark", an_n, 4'hF);
    go(20); chk("lz_d3_dark", an_n, 4'hF);
    go(23); value = 16'h0000; load = 1; step(1); load = 0;
    go(26); chk("lz_zero_d0_an", an_n, 4'b1110); chk("lz_zero_hex", digit_hex, 4'h0);
    go(32); chk("lz_zero_d1_dark", an_n, 4'hF);
`endif

    step(5);
    check_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
